// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF = 4096;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/ifu_pc_legal_chk.sv
// Alignment and range check of a byte address against the instruction memory window.
module pc_legal_chk #(
    parameter logic [31:0] IM_BASE  = ifu_pkg::IM_BASE_DEF,
    parameter int unsigned IM_WORDS = ifu_pkg::IM_WORDS_DEF
) (
    input  logic [31:0] addr,
    output logic        legal
);
    // 33-bit end bound so a window touching 2^32 cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    assign legal = (addr[1:0] == 2'b00) && (addr >= IM_BASE) && ({1'b0, addr} < IM_END);

endmodule

// File: rtl/ifu.sv
// Fetch unit: PC register, imem req/ready fetch, decode valid/ack handoff.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        instr_ack,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_exc,
    output logic [31:0] fetch_count
);
    ifu_state_t st, st_nxt;
    logic       pc_legal;

    pc_legal_chk #(.IM_BASE(IM_BASE), .IM_WORDS(IM_WORDS)) u_chk (
        .addr  (pc),
        .legal (pc_legal)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else        st <= st_nxt;
    end

    // Outputs depend on state and pc only; handshake inputs affect next state.
    always_comb begin
        st_nxt      = st;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (st)
            IDLE: st_nxt = REQ;
            REQ: begin
                imem_req = pc_legal;
                if (!pc_legal || imem_ready) st_nxt = HOLD;
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) st_nxt = REQ;
            end
            default: st_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instr       <= NOP_WORD;
            fetch_exc   <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            if (st == REQ) begin
                // Illegal PCs turn into a flagged nop without a memory access.
                if (!pc_legal) begin
                    instr     <= NOP_WORD;
                    fetch_exc <= 1'b1;
                end else if (imem_ready) begin
                    instr     <= imem_rdata;
                    fetch_exc <= 1'b0;
                end
            end
            if (st == HOLD && instr_ack) begin
                pc          <= npc;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
